// File: rtl/wb_timer.sv
// Wishbone-mapped 32-bit timer: prescaler, compare/match with optional auto-reload,
// and a level interrupt. Single-cycle registered acknowledge with a registered read bus.
module wb_timer #(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PRESC  = 3'd1,
        REG_COUNT  = 3'd2,
        REG_CMP    = 3'd3,
        REG_STATUS = 3'd4
    } reg_idx_e;

    logic [2:0]         ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pc_q,    pc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q,   cmp_d;
    logic               match_q, match_d;
    logic               ack_q,   ack_d;
    logic [31:0]        dat_q,   dat_d;

    logic        access;
    logic        wr_en;
    logic        tick;
    logic        cnt_hit;
    logic [31:0] wmask;
    logic [31:0] rdata;
    reg_idx_e    reg_idx;

    logic unused_adr;
    assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};

    assign reg_idx = reg_idx_e'(adr_i[4:2]);
    assign access  = cyc_i & stb_i & ~ack_q;
    assign wr_en   = access & we_i;
    assign wmask   = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

    assign tick    = ctrl_q[0] & (pc_q == presc_q);
    assign cnt_hit = tick & (count_q == cmp_q);

    // Read data reflects register contents before this cycle's tick or write.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata[2:0]         = ctrl_q;
            REG_PRESC:  rdata[PRESC_W-1:0] = presc_q;
            REG_COUNT:  rdata              = count_q;
            REG_CMP:    rdata              = cmp_q;
            REG_STATUS: rdata[0]           = match_q;
            default:    rdata              = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state value starts from its hold value so no path infers a latch.
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pc_d    = pc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;

        if (tick) begin
            pc_d    = '0;
            count_d = (cnt_hit & ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end else if (ctrl_q[0]) begin
            pc_d = pc_q + PRESC_W'(1);
        end

        if (cnt_hit) begin
            match_d = 1'b1;
        end

        // Bus writes override the tick update of the same cycle.
        if (wr_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    if (sel_i[0]) ctrl_d = dat_i[2:0];
                end
                REG_PRESC: begin
                    presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (dat_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
                    pc_d    = '0;
                end
                REG_COUNT: begin
                    count_d = (count_q & ~wmask) | (dat_i & wmask);
                    pc_d    = '0;
                end
                REG_CMP: begin
                    cmp_d = (cmp_q & ~wmask) | (dat_i & wmask);
                end
                REG_STATUS: begin
                    if (sel_i[0] && dat_i[0] && !cnt_hit) match_d = 1'b0;
                end
                default: ;
            endcase
        end

        ack_d = access;
        dat_d = (access & ~we_i) ? rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pc_q    <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = match_q & ctrl_q[2];

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios with literal expectations,
// then randomized bus traffic compared every cycle against a behavioural model.
module tb_wb_timer;

    localparam int PRESC_W = 16;
    localparam logic [31:0] PRESC_MASK = (32'd1 << PRESC_W) - 32'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_i, dat_i, dat_o;
    logic        we_i, stb_i, cyc_i, ack_o, irq_o;
    logic [3:0]  sel_i;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    wb_timer #(.PRESC_W(PRESC_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .sel_i (sel_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers plus the bus response it owes.
    logic [2:0]  m_ctrl;
    logic [31:0] m_presc, m_pc, m_count, m_cmp, m_dat;
    logic        m_match, m_ack;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? din[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        logic        start, tick, hit;
        logic [2:0]  idx;
        logic [31:0] rd, n_count, n_pc, n_presc, n_cmp;
        logic [2:0]  n_ctrl;
        logic        n_match;
        if (rst) begin
            m_ctrl <= '0; m_presc <= '0; m_pc <= '0; m_count <= '0; m_cmp <= '0;
            m_match <= 1'b0; m_ack <= 1'b0; m_dat <= '0;
        end else begin
            start = cyc_i && stb_i && !m_ack;
            idx   = adr_i[4:2];
            tick  = m_ctrl[0] && (m_pc == m_presc);
            hit   = tick && (m_count == m_cmp);
            case (idx)
                3'd0:    rd = {29'd0, m_ctrl};
                3'd1:    rd = m_presc;
                3'd2:    rd = m_count;
                3'd3:    rd = m_cmp;
                3'd4:    rd = {31'd0, m_match};
                default: rd = 32'd0;
            endcase
            n_ctrl = m_ctrl; n_presc = m_presc; n_cmp = m_cmp; n_match = m_match;
            n_count = m_count; n_pc = m_pc;
            if (tick) begin
                n_pc    = 0;
                n_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
            end else if (m_ctrl[0]) begin
                n_pc = m_pc + 1;
            end
            if (hit) n_match = 1'b1;
            if (start && we_i) begin
                case (idx)
                    3'd0: if (sel_i[0]) n_ctrl = dat_i[2:0];
                    3'd1: begin n_presc = merge(m_presc, dat_i, sel_i) & PRESC_MASK; n_pc = 0; end
                    3'd2: begin n_count = merge(m_count, dat_i, sel_i); n_pc = 0; end
                    3'd3: n_cmp = merge(m_cmp, dat_i, sel_i);
                    3'd4: if (sel_i[0] && dat_i[0] && !hit) n_match = 1'b0;
                    default: ;
                endcase
            end
            m_ctrl <= n_ctrl; m_presc <= n_presc; m_cmp <= n_cmp; m_match <= n_match;
            m_count <= n_count; m_pc <= n_pc;
            m_ack <= start;
            m_dat <= (start && !we_i) ? rd : 32'd0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
            check("dat_o", dat_o, m_dat);
            check("irq_o", {31'd0, irq_o}, {31'd0, m_match & m_ctrl[2]});
        end
    end

    task automatic bus_idle();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; adr_i = '0; dat_i = '0;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = {27'd0, idx, 2'b00}; dat_i = d; sel_i = s;
        @(posedge clk); #1;
        bus_idle();
        check("write_ack", {31'd0, ack_o}, 32'd1);
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = {27'd0, idx, 2'b00}; sel_i = 4'hF;
        @(posedge clk); #1;
        bus_idle();
        check("read_ack", {31'd0, ack_o}, 32'd1);
        d = dat_o;
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Reset values of every register and of an unmapped slot.
        for (int i = 0; i < 6; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("reset_reg%0d", i), rd, 32'd0);
        end

        // Reset during a write: not acknowledged, no side effect.
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0; dat_i = 32'h7; sel_i = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        check("abort_ack", {31'd0, ack_o}, 32'd0);
        bus_read(3'd0, rd);
        check("abort_ctrl", rd, 32'd0);

        // Prescaled counting with compare, auto-reload and interrupt.
        bus_write(3'd1, 32'd3, 4'hF);
        bus_write(3'd3, 32'd2, 4'hF);
        bus_write(3'd0, 32'h7, 4'hF);
        n = 0;
        while (!irq_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("irq_latency", 32'(n), 32'd12);
        check("irq_high", {31'd0, irq_o}, 32'd1);
        bus_read(3'd2, rd);
        check("count_reloaded", rd, 32'd0);

        // Clear coinciding with the next match tick: set wins.
        repeat (8) @(posedge clk);
        bus_write(3'd4, 32'd1, 4'h1);
        bus_read(3'd4, rd);
        check("match_set_wins", rd, 32'd1);
        check("irq_still_high", {31'd0, irq_o}, 32'd1);
        bus_write(3'd4, 32'd1, 4'h1);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);
        bus_read(3'd4, rd);
        check("match_cleared", rd, 32'd0);

        // 32-bit wrap with no match flag, then freeze on disable.
        bus_write(3'd0, 32'd0, 4'hF);
        bus_write(3'd4, 32'd1, 4'h1);
        bus_write(3'd1, 32'd0, 4'hF);
        bus_write(3'd3, 32'd5, 4'hF);
        bus_write(3'd2, 32'hFFFF_FFFE, 4'hF);
        bus_write(3'd0, 32'h1, 4'hF);
        bus_read(3'd2, rd);
        check("count_ffffffff", rd, 32'hFFFF_FFFF);
        check("model_wrap", m_count, 32'd0);
        bus_read(3'd4, rd);
        check("wrap_no_match", rd, 32'd0);
        bus_write(3'd0, 32'd0, 4'hF);
        bus_read(3'd2, rd);
        check("count_frozen", rd, 32'd4);

        // COUNT byte write colliding with a tick.
        bus_write(3'd1, 32'd1, 4'hF);
        bus_write(3'd2, 32'h0000_1234, 4'hF);
        bus_write(3'd0, 32'h1, 4'hF);
        bus_write(3'd2, 32'h0000_0100, 4'h1);
        check("model_pc_cleared", m_pc, 32'd0);
        check("model_count_merge", m_count, 32'h0000_1200);
        bus_read(3'd2, rd);
        check("count_write_wins", rd, 32'h0000_1200);
        bus_write(3'd0, 32'd0, 4'hF);

        // Strobe held for six cycles reading CMP.
        bus_write(3'd3, 32'hA5A5_0003, 4'hF);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'hC; sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("held_ack_c%0d", i + 1), {31'd0, ack_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("held_dat_c%0d", i + 1), dat_o, (i % 2 == 1) ? 32'hA5A5_0003 : 32'd0);
            @(posedge clk); #1;
        end
        bus_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 399) == 0);
            cyc_i = ($urandom_range(0, 9) < 7);
            stb_i = ($urandom_range(0, 9) < 8);
            we_i  = $urandom_range(0, 1);
            adr_i = $urandom;
            sel_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            dat_i = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 6)) : $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_idle();
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
